// File: rtl/clint_timer_if.sv
// Bus bundle for the CLINT timer block.
// One request/response handshake, slave side in the timer.
interface clint_timer_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [15:0]     req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic [3:0]      req_wstrb_i;
  logic            rsp_valid_o;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i,
    input  req_wdata_i, req_wstrb_i,
    output req_ready_o, rsp_valid_o,
    output rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i,
    output req_wdata_i, req_wstrb_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/clint_timer.sv
// RISC-V CLINT: mtime/mtimecmp timer and MSIP,
// behind a two-state request/response bus.
module clint_timer #(
  parameter int TICK_DIV = 1,
  parameter int XLEN     = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  clint_timer_if.slave  bus,
  output logic          timer_irq_o,
  output logic          sw_irq_o
);

  localparam logic [15:0] A_MSIP = 16'h0000;
  localparam logic [15:0] A_CLO  = 16'h4000;
  localparam logic [15:0] A_CHI  = 16'h4004;
  localparam logic [15:0] A_TLO  = 16'hBFF8;
  localparam logic [15:0] A_THI  = 16'hBFFC;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t          r_state;
  logic [15:0]     r_presc;
  logic [63:0]     r_mtime;
  logic [63:0]     r_cmp;
  logic [31:0]     r_shadow;
  logic            r_msip;
  logic            r_tirq;
  logic            r_rsp_v;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic        w_acc;
  logic        w_we;
  logic        w_sel_msip;
  logic        w_sel_clo;
  logic        w_sel_chi;
  logic        w_sel_tlo;
  logic        w_sel_thi;
  logic        w_hit;
  logic        w_tick;
  logic [31:0] w_wd;
  logic [3:0]  w_st;
  logic [31:0] w_rd32;
  logic [31:0] w_thi_new;
  logic [63:0] w_mtime_nxt;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  st
  );
    logic [31:0] m;
    for (int b = 0; b < 4; b++)
      m[8*b +: 8] = st[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return m;
  endfunction

  assign w_acc  = (r_state == S_IDLE) & bus.req_valid_i;
  assign w_we   = bus.req_we_i;
  assign w_wd   = bus.req_wdata_i[31:0];
  assign w_st   = bus.req_wstrb_i;
  assign w_tick = (r_presc == 16'(TICK_DIV - 1));
  assign w_thi_new = merge(r_mtime[63:32], w_wd, w_st);

  always_comb begin
    w_sel_msip = 1'b0;
    w_sel_clo  = 1'b0;
    w_sel_chi  = 1'b0;
    w_sel_tlo  = 1'b0;
    w_sel_thi  = 1'b0;
    w_hit      = 1'b1;
    unique case (1'b1)
      (bus.req_addr_i == A_MSIP): w_sel_msip = 1'b1;
      (bus.req_addr_i == A_CLO):  w_sel_clo  = 1'b1;
      (bus.req_addr_i == A_CHI):  w_sel_chi  = 1'b1;
      (bus.req_addr_i == A_TLO):  w_sel_tlo  = 1'b1;
      (bus.req_addr_i == A_THI):  w_sel_thi  = 1'b1;
      default:                    w_hit      = 1'b0;
    endcase
  end

  always_comb begin
    w_rd32 = '0;
    unique case (1'b1)
      w_sel_msip: w_rd32 = {31'b0, r_msip};
      w_sel_clo:  w_rd32 = r_cmp[31:0];
      w_sel_chi:  w_rd32 = r_cmp[63:32];
      w_sel_tlo:  w_rd32 = r_mtime[31:0];
      w_sel_thi:  w_rd32 = r_shadow;
      default:    w_rd32 = '0;
    endcase
  end

  // A bus write to one half beats the tick; the other half sees no carry.
  always_comb begin
    w_mtime_nxt = r_mtime + {63'b0, w_tick};
    if (w_acc & w_we & w_sel_tlo)
      w_mtime_nxt = {r_mtime[63:32],
                     merge(r_mtime[31:0], w_wd, w_st)};
    else if (w_acc & w_we & w_sel_thi)
      w_mtime_nxt = {w_thi_new, r_mtime[31:0]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_mtime  <= '0;
      r_cmp    <= '1;
      r_shadow <= '0;
      r_msip   <= 1'b0;
      r_tirq   <= 1'b0;
      r_rsp_v  <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      r_mtime <= w_mtime_nxt;
      r_tirq  <= (r_mtime >= r_cmp);
      unique case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_state <= S_RESP;
            r_rsp_v <= 1'b1;
            r_err   <= ~w_hit;
            r_rdata <= w_we ? '0 : XLEN'(w_rd32);
            if (w_we) begin
              if (w_sel_msip & w_st[0]) r_msip <= w_wd[0];
              if (w_sel_clo)
                r_cmp[31:0] <= merge(r_cmp[31:0], w_wd, w_st);
              if (w_sel_chi)
                r_cmp[63:32] <= merge(r_cmp[63:32], w_wd, w_st);
              if (w_sel_thi) r_shadow <= w_thi_new;
            end else if (w_sel_tlo) begin
              r_shadow <= r_mtime[63:32];
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_rsp_v <= 1'b0;
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  assign bus.req_ready_o = (r_state == S_IDLE) & ~rst_i;
  assign bus.rsp_valid_o = r_rsp_v & ~rst_i;
  assign bus.rsp_rdata_o = r_rdata & {XLEN{~rst_i}};
  assign bus.rsp_err_o   = r_err & ~rst_i;
  assign timer_irq_o     = r_tirq & ~rst_i;
  assign sw_irq_o        = r_msip & ~rst_i;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench: two timers, TICK_DIV 1 and 4,
// shared clock and reset.
module tb_clint_timer;

  localparam logic [15:0] A_MSIP = 16'h0000;
  localparam logic [15:0] A_CLO  = 16'h4000;
  localparam logic [15:0] A_CHI  = 16'h4004;
  localparam logic [15:0] A_TLO  = 16'hBFF8;
  localparam logic [15:0] A_THI  = 16'hBFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0;
  logic        v1 = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        irq0, sw0, irq1, sw1;
  int          cyc = 0;
  int          c0 = 0;
  int          n_tot = 0;
  int          n_bad = 0;

  clint_timer_if #(.XLEN(32)) b0 ();
  clint_timer_if #(.XLEN(32)) b1 ();

  assign b0.req_valid_i = v0;
  assign b0.req_we_i    = we;
  assign b0.req_addr_i  = addr;
  assign b0.req_wdata_i = wdata;
  assign b0.req_wstrb_i = wstrb;
  assign b1.req_valid_i = v1;
  assign b1.req_we_i    = we;
  assign b1.req_addr_i  = addr;
  assign b1.req_wdata_i = wdata;
  assign b1.req_wstrb_i = wstrb;

  clint_timer #(.TICK_DIV(1), .XLEN(32)) u0 (
    .clk_i(clk), .rst_i(rst), .bus(b0.slave),
    .timer_irq_o(irq0), .sw_irq_o(sw0)
  );

  clint_timer #(.TICK_DIV(4), .XLEN(32)) u1 (
    .clk_i(clk), .rst_i(rst), .bus(b1.slave),
    .timer_irq_o(irq1), .sw_irq_o(sw1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? b0.req_ready_o : b1.req_ready_o;
  endfunction

  function automatic logic rsv(input int d);
    return (d == 0) ? b0.rsp_valid_o : b1.rsp_valid_o;
  endfunction

  // Called on a negedge, returns on the negedge after acceptance.
  task automatic xfer(
    input  int          d,
    input  logic        w,
    input  logic [15:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  st,
    output logic [31:0] rd,
    output logic        er
  );
    int n = 0;
    we = w; addr = a; wdata = wd; wstrb = st;
    if (d == 0) v0 = 1'b1; else v1 = 1'b1;
    while (!rdy(d) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("rdy", {63'b0, rdy(d)}, 64'd1);
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    chk("rspv", {63'b0, rsv(d)}, 64'd1);
    rd = (d == 0) ? b0.rsp_rdata_o : b1.rsp_rdata_o;
    er = (d == 0) ? b0.rsp_err_o : b1.rsp_err_o;
    @(negedge clk);
  endtask

  logic [31:0] rd, lo, hi;
  logic        er;
  int          acc_c;
  int          acc, rsps, bad_alt;
  logic        r_now, r_prev;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'b0, b0.req_ready_o}, 64'd0);
    chk("rst_rspv", {63'b0, b0.rsp_valid_o}, 64'd0);
    chk("rst_irq", {63'b0, irq0}, 64'd0);
    chk("rst_sw", {63'b0, sw0}, 64'd0);
    rst = 1'b0;
    c0 = cyc;

    repeat (10) @(negedge clk);
    xfer(0, 1'b0, A_TLO, 0, 0, rd, er);
    chk("mtime10", {32'b0, rd}, 64'd10);
    chk("irq_idle", {63'b0, irq0}, 64'd0);

    xfer(0, 1'b1, A_CHI, 32'h0, 4'hF, rd, er);
    xfer(0, 1'b1, A_CLO, 32'd50, 4'hF, rd, er);
    xfer(0, 1'b1, A_TLO, 32'h0, 4'hF, rd, er);
    acc_c = cyc;
    while (cyc < acc_c + 50) @(negedge clk);
    chk("irq_at50", {63'b0, irq0}, 64'd0);
    @(negedge clk);
    chk("irq_rise", {63'b0, irq0}, 64'd1);
    xfer(0, 1'b1, A_CLO, 32'hFFFF_FFFF, 4'hF, rd, er);
    chk("irq_hold", {63'b0, irq0}, 64'd1);
    @(negedge clk);
    chk("irq_fall", {63'b0, irq0}, 64'd0);

    xfer(0, 1'b1, A_THI, 32'h0, 4'hF, rd, er);
    xfer(0, 1'b1, A_TLO, 32'hFFFF_FFFE, 4'hF, rd, er);
    xfer(0, 1'b0, A_TLO, 0, 0, lo, er);
    xfer(0, 1'b0, A_THI, 0, 0, hi, er);
    chk("snap", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    xfer(0, 1'b0, A_TLO, 0, 0, lo, er);
    xfer(0, 1'b0, A_THI, 0, 0, hi, er);
    chk("carry_lo", {32'b0, lo}, 64'd3);
    chk("carry_hi", {32'b0, hi}, 64'd1);

    xfer(0, 1'b1, A_CHI, 32'hAABB_CCDD, 4'b0101, rd, er);
    xfer(0, 1'b0, A_CHI, 0, 0, rd, er);
    chk("wstrb", {32'b0, rd}, 64'h00BB_00DD);

    xfer(0, 1'b1, A_MSIP, 32'hFFFF_FFFF, 4'hF, rd, er);
    chk("sw_set", {63'b0, sw0}, 64'd1);
    xfer(0, 1'b0, A_MSIP, 0, 0, rd, er);
    chk("msip_rd", {32'b0, rd}, 64'd1);
    chk("ok_err", {63'b0, er}, 64'd0);
    xfer(0, 1'b1, A_MSIP, 32'h0, 4'hF, rd, er);
    chk("sw_clr", {63'b0, sw0}, 64'd0);

    xfer(0, 1'b0, 16'h1000, 0, 0, rd, er);
    chk("bad_err", {63'b0, er}, 64'd1);
    chk("bad_data", {32'b0, rd}, 64'd0);

    acc = 0; rsps = 0; bad_alt = 0; r_prev = 1'b1;
    we = 1'b0; addr = A_MSIP; v0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r_now = b0.req_ready_o;
      if (r_now) acc++;
      if (i > 0 && r_now == r_prev) bad_alt++;
      r_prev = r_now;
      @(posedge clk);
      #1;
      if (b0.rsp_valid_o) rsps++;
      @(negedge clk);
    end
    v0 = 1'b0;
    chk("b2b_alt", bad_alt, 0);
    chk("b2b_acc", acc, 4);
    chk("b2b_rsp", rsps, acc);

    xfer(1, 1'b1, A_THI, 32'h0, 4'hF, rd, er);
    @(negedge clk);
    while (((cyc + 1 - c0) % 4) != 2) @(negedge clk);
    xfer(1, 1'b1, A_TLO, 32'hFFFF_FFFF, 4'hF, rd, er);
    xfer(1, 1'b1, A_TLO, 32'h0000_1234, 4'hF, rd, er);
    xfer(1, 1'b0, A_TLO, 0, 0, lo, er);
    xfer(1, 1'b0, A_THI, 0, 0, hi, er);
    chk("wrap_lo", {32'b0, lo}, 64'h1234);
    chk("wrap_hi", {32'b0, hi}, 64'h0);
    xfer(1, 1'b0, A_TLO, 0, 0, lo, er);
    chk("div4_lo", {32'b0, lo}, 64'h1235);

    xfer(1, 1'b1, A_MSIP, 32'h1, 4'hF, rd, er);
    xfer(1, 1'b1, A_CHI, 32'h0, 4'hF, rd, er);
    xfer(1, 1'b1, A_CLO, 32'h0, 4'hF, rd, er);
    @(negedge clk);
    chk("pre_irq1", {63'b0, irq1}, 64'd1);
    chk("pre_sw1", {63'b0, sw1}, 64'd1);
    we = 1'b0; addr = A_MSIP; v1 = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    v1 = 1'b0;
    @(negedge clk);
    chk("rr_rspv", {63'b0, b1.rsp_valid_o}, 64'd0);
    chk("rr_ready", {63'b0, b1.req_ready_o}, 64'd0);
    chk("rr_rdata", {32'b0, b1.rsp_rdata_o}, 64'd0);
    chk("rr_err", {63'b0, b1.rsp_err_o}, 64'd0);
    chk("rr_irq", {63'b0, irq1}, 64'd0);
    chk("rr_sw", {63'b0, sw1}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rsps = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (b1.rsp_valid_o) rsps++;
    end
    @(negedge clk);
    chk("rr_norsp", rsps, 0);
    xfer(1, 1'b0, A_MSIP, 0, 0, rd, er);
    chk("rr_msip", {32'b0, rd}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, meaning clk_i cycles per mtime increment (range 1..65535).
REQ-002 SHALL have parameter XLEN, default 32, meaning data width of the bus.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  1  bus request valid.
REQ-006 SHALL have port req_ready_o  output  1  bus request accepted this cycle.
REQ-007 SHALL have port req_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i  input  16  byte offset within the block.
REQ-009 SHALL have port req_wdata_i  input  XLEN  write data.
REQ-010 SHALL have port req_wstrb_i  input  4  byte write enables.
REQ-011 SHALL have port rsp_valid_o  output  1  response valid; a single-cycle pulse.
REQ-012 SHALL have port rsp_rdata_o  output  XLEN  read data; 0 for writes.
REQ-013 SHALL have port rsp_err_o  output  1  access to an unmapped offset.
REQ-014 SHALL have port timer_irq_o  output  1  machine timer interrupt pending (MTIP source for mip bit 7).
REQ-015 SHALL have port sw_irq_o  output  1  machine software interrupt pending (MSIP source for mip bit 3).

Function
REQ-016 SHALL map registers as follows: MSIP at 0x0000 (bit 0 RW, other bits read 0); MTIMECMP_LO at 0x4000; MTIMECMP_HI at 0x4004; MTIME_LO at 0xBFF8; MTIME_HI at 0xBFFC.
REQ-017 SHALL use a two-state bus FSM: IDLE and RESP.
- IDLE: req_ready_o = 1. On req_valid_i, perform the access and go to RESP.
- RESP: rsp_valid_o = 1 and req_ready_o = 0, then return to IDLE.
- Throughput: one access per two cycles.
REQ-018 SHALL register read data in the IDLE->RESP transition, so rsp_rdata_o reflects register state at acceptance.
REQ-019 SHALL apply writes at acceptance, honouring req_wstrb_i per byte.
REQ-020 SHALL give an unmapped offset the following response: rsp_err_o = 1, rsp_rdata_o = 0, no state change.
REQ-021 SHALL keep a prescaler counter 0..TICK_DIV-1.
- mtime (64-bit) increments by 1 when the prescaler wraps to 0.
- The prescaler is free-running.
REQ-022 SHALL give a software write to MTIME_LO/HI priority over a same-cycle increment: the written half takes the write value, and the other half keeps its pre-increment value (no carry into it that cycle).
REQ-023 SHALL let mtime wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 without a flag.
REQ-024 SHALL capture mtime[63:32] into a shadow register when MTIME_LO is read; a read of MTIME_HI returns the shadow. This gives a consistent 64-bit snapshot for lo-then-hi reads.
REQ-025 SHALL update the shadow on MTIME_HI writes as well, to the new high word.
REQ-026 SHALL drive timer_irq_o as a register set to (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on post-update values. Latency: one cycle after the causing change.
REQ-027 SHALL drive sw_irq_o directly from MSIP bit 0.
REQ-028 SHALL NOT have writes to MTIMECMP_LO/HI block or delay mtime counting.

Reset
REQ-029 SHALL set the following on rst_i = 1 at a clock edge: mtime = 0, prescaler = 0, shadow = 0, MSIP = 0, mtimecmp = 0xFFFF_FFFF_FFFF_FFFF.
REQ-030 SHALL drive outputs in reset as: req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, timer_irq_o = 0, sw_irq_o = 0. The FSM enters IDLE on the first cycle after rst_i deasserts.
REQ-031 SHALL, if reset asserts while in RESP, drop the pending response (no rsp_valid_o pulse).

Verification
REQ-032 SHALL cover: reset with TICK_DIV = 1, wait 10 cycles -> MTIME_LO reads 10 ±1 (access-latency tolerance), timer_irq_o = 0.
REQ-033 SHALL cover: write MTIMECMP_HI = 0 and MTIMECMP_LO = 50 with mtime < 50 -> timer_irq_o rises exactly one cycle after mtime reaches 50. Then write MTIMECMP_LO = 0xFFFF_FFFF -> timer_irq_o falls one cycle later.
REQ-034 SHALL cover: write MTIME_HI = 0, MTIME_LO = 0xFFFF_FFFE, then wait 2 increments -> MTIME_LO reads near 0 and MTIME_HI reads 1. A lo-then-hi read straddling the carry returns a consistent pair.
REQ-035 SHALL cover: write MSIP = 0xFFFF_FFFF -> sw_irq_o = 1 and MSIP reads 0x1. Write 0 -> sw_irq_o = 0.
REQ-036 SHALL cover: read offset 0x1000 -> rsp_err_o = 1, rsp_rdata_o = 0. Back-to-back req_valid_i held high -> req_ready_o alternates 1/0 and every accepted request yields exactly one rsp_valid_o.
REQ-037 SHALL cover: TICK_DIV = 4, write MTIME_LO at the same cycle as a prescaler wrap -> the written value holds with no carry. Assert rst_i in RESP -> no response, and all outputs read as in REQ-030.
